// File: rtl/countdown_timer_pkg.sv
// Shared constants and state encoding for the seconds countdown timer and its tick source.
// No logic; types and parameters only.
// No flow control.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } timer_state_t;

    // Clocks per one-second tick at 50 MHz; the tick generator uses the same value.
    localparam int TICK_HZ_CLKS    = 50_000_000;
    localparam int DEFAULT_MAX_SEC = 99;

endpackage : countdown_timer_pkg

// File: rtl/sec_to_bcd.sv
// Binary seconds (0..99) to two BCD digits using a compare/subtract chain, no divider.
// Latency: combinational.
// Backpressure: none.
module sec_to_bcd #(
    parameter int W = 7
) (
    input  logic [W-1:0] bin,
    output logic [3:0]   tens,
    output logic [3:0]   ones
);

    // Internal width wide enough to hold the constant 90 even for small W.
    localparam int CW = (W > 7) ? W : 7;

    logic [CW-1:0] bin_x;
    logic [CW-1:0] diff;

    always_comb begin
        bin_x = CW'(bin);
        tens  = 4'd0;
        diff  = bin_x;
        // Ascending thresholds: the last one met decides the tens digit.
        for (int k = 1; k <= 9; k++) begin
            if (bin_x >= CW'(10 * k)) begin
                tens = 4'(k);
                diff = bin_x - CW'(10 * k);
            end
        end
        ones = 4'(diff);
    end

endmodule : sec_to_bcd

// File: rtl/countdown_timer.sv
// Seconds countdown timer: load, start/pause, decrement per tick, flag expiry, BCD display digits.
// Latency: 1 clk from tick/start/pause/load to registered outputs; BCD digits combinational from remaining.
// Backpressure: none; every request is acted on or dropped in the cycle it is presented.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int W       = 7,
    parameter int MAX_SEC = DEFAULT_MAX_SEC
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         start,
    input  logic         pause,
    output logic [W-1:0] remaining,
    output logic [3:0]   sec_tens,
    output logic [3:0]   sec_ones,
    output logic         running,
    output logic         paused,
    output logic         done,
    output logic         expired
);

    localparam logic [W-1:0] MAX_SEC_W = W'(MAX_SEC);

    timer_state_t state;
    timer_state_t state_nxt;
    logic [W-1:0] remaining_nxt;
    logic         expired_nxt;
    logic [W-1:0] load_clamped;

    assign load_clamped = (load_value > MAX_SEC_W) ? MAX_SEC_W : load_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            expired   <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            expired   <= expired_nxt;
        end
    end

    // Priority load > start > pause > tick; a request that does not apply in
    // the current state is ignored and does not block lower-priority ones.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        expired_nxt   = 1'b0;

        if (load && (state != ST_RUN)) begin
            remaining_nxt = load_clamped;
            state_nxt     = ST_IDLE;
        end else if (start && (((state == ST_IDLE) && (remaining != '0)) || (state == ST_PAUSE))) begin
            state_nxt = ST_RUN;
        end else if (pause && (state == ST_RUN)) begin
            state_nxt = ST_PAUSE;
        end else if (tick && (state == ST_RUN)) begin
            remaining_nxt = remaining - W'(1);
            if (remaining == W'(1)) begin
                state_nxt   = ST_DONE;
                expired_nxt = 1'b1;
            end
        end
    end

    assign running = (state == ST_RUN);
    assign paused  = (state == ST_PAUSE);
    assign done    = (state == ST_DONE);

    sec_to_bcd #(
        .W (W)
    ) u_sec_to_bcd (
        .bin  (remaining),
        .tens (sec_tens),
        .ones (sec_ones)
    );

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Table-driven bench for countdown_timer with an expected-result queue checked after each edge.
module tb_countdown_timer;

    localparam int W = 7;

    // flag encoding {running, paused, done, expired}
    localparam logic [3:0] F_IDLE  = 4'b0000;
    localparam logic [3:0] F_RUN   = 4'b1000;
    localparam logic [3:0] F_PAUSE = 4'b0100;
    localparam logic [3:0] F_DONE  = 4'b0010;
    localparam logic [3:0] F_EXP   = 4'b0011;

    typedef struct {
        string        name;
        logic         rst;
        logic         ld;
        logic [W-1:0] lv;
        logic         st;
        logic         ps;
        logic         tk;
        logic [W-1:0] rem;
        logic [3:0]   flags;
    } vec_t;

    typedef struct {
        string        name;
        logic [W-1:0] rem;
        logic [3:0]   flags;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         tick = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic [W-1:0] remaining;
    logic [3:0]   sec_tens;
    logic [3:0]   sec_ones;
    logic         running;
    logic         paused;
    logic         done;
    logic         expired;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];
    exp_t exp_q[$];

    countdown_timer #(.W(W), .MAX_SEC(99)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .remaining  (remaining),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .running    (running),
        .paused     (paused),
        .done       (done),
        .expired    (expired)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string name, logic rst, logic ld, int lv, logic st, logic ps,
                                logic tk, int rem, logic [3:0] flags);
        vec_t v;
        v.name = name; v.rst = rst; v.ld = ld; v.lv = W'(lv);
        v.st = st; v.ps = ps; v.tk = tk; v.rem = W'(rem); v.flags = flags;
        return v;
    endfunction

    // Drive one cycle of inputs, queue the expectation, then check it after the edge.
    task automatic apply(input vec_t v);
        exp_t e;
        logic [18:0] got;
        logic [18:0] want;
        @(negedge clk);
        reset = v.rst; load = v.ld; load_value = v.lv;
        start = v.st; pause = v.ps; tick = v.tk;
        e.name = v.name; e.rem = v.rem; e.flags = v.flags;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        want = {e.rem, 4'(e.rem / 10), 4'(e.rem % 10), e.flags};
        got  = {remaining, sec_tens, sec_ones, running, paused, done, expired};
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got rem=%0d bcd=%0d%0d r/p/d/e=%b, want rem=%0d bcd=%0d%0d r/p/d/e=%b",
                     e.name, remaining, sec_tens, sec_ones, {running, paused, done, expired},
                     e.rem, e.rem / 10, e.rem % 10, e.flags);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Countdown from 5 with ticks 10 cycles apart; checks every cycle incl. the single expired pulse.
        apply(mk("reset",   1, 0, 0, 0, 0, 0, 0, F_IDLE));
        apply(mk("load5",   0, 1, 5, 0, 0, 0, 5, F_IDLE));
        apply(mk("start5",  0, 0, 0, 1, 0, 0, 5, F_RUN));
        for (int i = 0; i < 5; i++) begin
            apply(mk("cd_tick", 0, 0, 0, 0, 0, 1, 4 - i, (i == 4) ? F_EXP : F_RUN));
            for (int j = 0; j < 9; j++)
                apply(mk("cd_hold", 0, 0, 0, 0, 0, 0, 4 - i, (i == 4) ? F_DONE : F_RUN));
        end

        vecs.push_back(mk("done_start",     0, 0, 0,   1, 0, 0, 0,  F_DONE));
        vecs.push_back(mk("done_tick",      0, 0, 0,   0, 0, 1, 0,  F_DONE));
        vecs.push_back(mk("done_st_tk",     0, 0, 0,   1, 0, 1, 0,  F_DONE));
        vecs.push_back(mk("done_load3",     0, 1, 3,   0, 0, 0, 3,  F_IDLE));
        vecs.push_back(mk("load23",         0, 1, 23,  0, 0, 0, 23, F_IDLE));
        vecs.push_back(mk("start23",        0, 0, 0,   1, 0, 0, 23, F_RUN));
        vecs.push_back(mk("t22",            0, 0, 0,   0, 0, 1, 22, F_RUN));
        vecs.push_back(mk("t21",            0, 0, 0,   0, 0, 1, 21, F_RUN));
        vecs.push_back(mk("t20",            0, 0, 0,   0, 0, 1, 20, F_RUN));
        vecs.push_back(mk("pause20",        0, 0, 0,   0, 1, 0, 20, F_PAUSE));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk("pause_tick", 0, 0, 0,   0, 0, 1, 20, F_PAUSE));
        vecs.push_back(mk("resume",         0, 0, 0,   1, 0, 0, 20, F_RUN));
        vecs.push_back(mk("t19",            0, 0, 0,   0, 0, 1, 19, F_RUN));
        vecs.push_back(mk("run_load50",     0, 1, 50,  0, 0, 0, 19, F_RUN));
        vecs.push_back(mk("t18",            0, 0, 0,   0, 0, 1, 18, F_RUN));
        vecs.push_back(mk("run_ld_tick",    0, 1, 50,  0, 0, 1, 17, F_RUN));
        vecs.push_back(mk("tick_pause",     0, 0, 0,   0, 1, 1, 17, F_PAUSE));
        vecs.push_back(mk("load120",        0, 1, 120, 0, 0, 0, 99, F_IDLE));
        vecs.push_back(mk("load100",        0, 1, 100, 0, 0, 0, 99, F_IDLE));
        vecs.push_back(mk("load0",          0, 1, 0,   0, 0, 0, 0,  F_IDLE));
        vecs.push_back(mk("start_zero",     0, 0, 0,   1, 0, 0, 0,  F_IDLE));
        vecs.push_back(mk("load7",          0, 1, 7,   0, 0, 0, 7,  F_IDLE));
        vecs.push_back(mk("idle_tick",      0, 0, 0,   0, 0, 1, 7,  F_IDLE));
        vecs.push_back(mk("idle_pause",     0, 0, 0,   0, 1, 0, 7,  F_IDLE));
        vecs.push_back(mk("start_tick7",    0, 0, 0,   1, 0, 1, 7,  F_RUN));
        vecs.push_back(mk("run7_tk_ps",     0, 0, 0,   0, 1, 1, 7,  F_PAUSE));
        vecs.push_back(mk("pause_st_tk",    0, 0, 0,   1, 0, 1, 7,  F_RUN));
        vecs.push_back(mk("t6",             0, 0, 0,   0, 0, 1, 6,  F_RUN));
        vecs.push_back(mk("pause6",         0, 0, 0,   0, 1, 0, 6,  F_PAUSE));
        vecs.push_back(mk("pause_load12",   0, 1, 12,  1, 0, 0, 12, F_IDLE));
        vecs.push_back(mk("idle_ld_st",     0, 1, 12,  1, 0, 0, 12, F_IDLE));
        vecs.push_back(mk("start12",        0, 0, 0,   1, 0, 0, 12, F_RUN));
        vecs.push_back(mk("reset_run12",    1, 0, 0,   0, 0, 1, 0,  F_IDLE));
        vecs.push_back(mk("after_reset",    0, 0, 0,   0, 0, 1, 0,  F_IDLE));
        vecs.push_back(mk("load1",          0, 1, 1,   0, 0, 0, 1,  F_IDLE));
        vecs.push_back(mk("start1",         0, 0, 0,   1, 0, 0, 1,  F_RUN));
        vecs.push_back(mk("reset_at_exp",   1, 0, 0,   0, 0, 1, 0,  F_IDLE));
        vecs.push_back(mk("no_late_exp",    0, 0, 0,   0, 0, 0, 0,  F_IDLE));
        vecs.push_back(mk("load2",          0, 1, 2,   0, 0, 0, 2,  F_IDLE));
        vecs.push_back(mk("start2",         0, 0, 0,   1, 0, 0, 2,  F_RUN));
        vecs.push_back(mk("t1",             0, 0, 0,   0, 0, 1, 1,  F_RUN));
        vecs.push_back(mk("t0_expire",      0, 0, 0,   0, 0, 1, 0,  F_EXP));
        vecs.push_back(mk("done_no_wrap",   0, 0, 0,   0, 0, 1, 0,  F_DONE));
        vecs.push_back(mk("done_pause",     0, 0, 0,   0, 1, 0, 0,  F_DONE));
        vecs.push_back(mk("reset_ld",       1, 1, 40,  1, 0, 0, 0,  F_IDLE));
        vecs.push_back(mk("load99",         0, 1, 99,  0, 0, 0, 99, F_IDLE));
        vecs.push_back(mk("load58",         0, 1, 58,  0, 0, 0, 58, F_IDLE));
        vecs.push_back(mk("load10",         0, 1, 10,  0, 0, 0, 10, F_IDLE));
        vecs.push_back(mk("start10",        0, 0, 0,   1, 0, 0, 10, F_RUN));
        vecs.push_back(mk("t9",             0, 0, 0,   0, 0, 1, 9,  F_RUN));

        foreach (vecs[i]) apply(vecs[i]);

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_countdown_timer

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Seconds countdown timer. It consumes the one-cycle `ovflw` pulse that the one-second tick generator produces on every 50,000,000th enabled clock.
- It loads a seconds value, decrements it on each tick while running, and flags expiry.
- It drives a two-digit BCD display path (`sec_tens`, `sec_ones`) for the 7-segment decoders.

Parameters:
- W, 7, width of the seconds counter and of `load_value`.
- MAX_SEC, 99, largest loadable value; must satisfy MAX_SEC ≤ 99 and MAX_SEC < 2^W.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- tick  in  1  one-second pulse from the tick generator's `ovflw`; exactly 1 clk wide.
- load  in  1  load request; 1-cycle pulse or level.
- load_value  in  W  seconds to load.
- start  in  1  start/resume request.
- pause  in  1  pause request.
- remaining  out  W  current seconds remaining (registered).
- sec_tens  out  4  BCD tens digit of `remaining`.
- sec_ones  out  4  BCD ones digit of `remaining`.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- done  out  1  level; high in DONE.
- expired  out  1  1-cycle pulse on entry to DONE.

Behaviour:
- All state updates on rising `clk`. Reset is sampled only on the clock edge.
- Reset: state=IDLE, `remaining`=0, `running`=`paused`=`done`=`expired`=0; hence `sec_tens`=`sec_ones`=0.
- States: IDLE, RUN, PAUSE, DONE. `running`, `paused` and `done` decode directly from the state register (registered, no combinational input paths).
- Per-cycle priority: reset > load > start > pause > tick.
- load in IDLE, PAUSE or DONE:
  - `remaining` <= min(`load_value`, MAX_SEC); next state IDLE.
  - This clears `done` and `paused`.
- load in RUN: ignored.
- start:
  - IDLE with `remaining`≠0 → RUN.
  - IDLE with `remaining`=0 → ignored, stays IDLE.
  - PAUSE → RUN.
  - DONE → ignored.
- pause:
  - RUN → PAUSE.
  - Any other state: ignored.
- tick in RUN, with no pause in the same cycle:
  - `remaining` <= `remaining`-1, visible the cycle after the tick.
  - If `remaining`==1: `remaining` <= 0, state <= DONE, and `expired`=1 for exactly that next cycle.
- tick in IDLE, PAUSE or DONE: ignored; `remaining` unchanged.
- Simultaneous events:
  - tick with pause in RUN: pause wins; the tick is dropped; `remaining` unchanged.
  - tick with start in IDLE or PAUSE: the tick is not counted; the first decrement comes on the next tick.
  - load with start in IDLE: load wins; start is ignored; a new start is needed.
- No wrap: `remaining` never decrements below 0. RUN with `remaining`=0 is unreachable.
- DONE persists; `done`=1 until reset or load.
- Reset mid-RUN: all outputs return to reset values on the next edge; no `expired` pulse.
- Latency:
  - tick → `remaining` update: 1 cycle.
  - tick → `done` and `expired`: 1 cycle.
  - start → `running`: 1 cycle.
- BCD conversion:
  - Combinational from registered `remaining`.
  - `sec_tens` = `remaining`/10, `sec_ones` = `remaining`%10, valid for 0..99.
  - No arithmetic divider: comparator/subtract chain.

Decomposition:
- Shared package holds:
  - state encodings (IDLE=0, RUN=1, PAUSE=2, DONE=3, 2-bit);
  - TICK_HZ_CLKS=50_000_000 (shared with the tick generator);
  - default MAX_SEC=99.
- One natural sub-module: `sec_to_bcd` (W-bit binary in, two 4-bit BCD digits out; combinational, reusable by other display blocks).
- The FSM, counter and pulse logic stay in `countdown_timer`.

Test Plan:
- Reset, then load `load_value`=5, start, then 5 ticks 10 cycles apart → `remaining` steps 5,4,3,2,1,0, each 1 cycle after its tick. `expired` is a single 1-cycle pulse with `done`=1 from the 5th tick+1 onward. `running`=0 after that.
- Load 23, start, 3 ticks, pause, 4 ticks, start, 1 tick → `remaining` 23→20; held at 20 through PAUSE with `paused`=1; then 19. `sec_tens`/`sec_ones` = 1/9.
- Load 120 with MAX_SEC=99 → `remaining`=99, `sec_tens`=9, `sec_ones`=9. Load 0 then start → stays IDLE, `running`=0.
- Simultaneous events:
  - RUN at 7: tick+pause same cycle → `remaining`=7, PAUSE.
  - IDLE at 7: start+tick same cycle → `remaining`=7, RUN.
  - load during RUN (`load_value`=50) → ignored, countdown continues.
- Reset asserted mid-RUN at `remaining`=12 for 1 cycle → next cycle all outputs 0, state IDLE, no `expired`.
- In DONE, start and further ticks → `done` stays 1, `remaining` stays 0. Then load 3 → `done`=0, `remaining`=3, IDLE.
